// File: rtl/gclk_chk_pkg.sv
// gclk_chk_pkg: shared types and the consequent selector for the global-clock edge checker
package gclk_chk_pkg;
  typedef enum logic [1:0] {CHK_FALL, CHK_RISE, CHK_STABLE, CHK_CHANGE} chk_mode_e;
  typedef enum logic [1:0] {IDLE, ARM, RUN} chk_state_e;
  typedef struct packed {
    logic changing;
    logic rising;
    logic falling;
    logic stable;
  } pair_flags_t;
  function automatic logic chk_cons(chk_mode_e m, pair_flags_t f);
    return m == CHK_FALL ? f.falling : m == CHK_RISE ? f.rising : m == CHK_STABLE ? f.stable : f.changing;
  endfunction
endpackage

// File: rtl/gclk_sample_pair.sv
// gclk_sample_pair: past-sample register (clk, rst, ld, d -> q) plus changing/rising/falling/stable flags of the (q, d) pair
module gclk_sample_pair import gclk_chk_pkg::*; #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output pair_flags_t  f
);
  always_ff @(posedge clk)
    q <= rst ? '0 : ld ? d : q;
  // For multi-bit buses rising/falling mean some bit rose/fell.
  assign f = {d != q, |(~q & d), |(q & ~d), d == q};
endmodule

// File: rtl/gclk_edge_check_ctrl.sv
// gclk_edge_check_ctrl: checks "sig changing |-> strb shows MODE transition" per tick; ports: clk, rst, en, sig, strb in; viol_* report (valid/ready), viol_cnt, overflow, busy out
module gclk_edge_check_ctrl import gclk_chk_pkg::*; #(
  parameter int        W     = 1,
  parameter int        CNT_W = 16,
  parameter chk_mode_e MODE  = CHK_FALL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [W-1:0]     sig,
  input  logic             strb,
  output logic             viol_valid,
  input  logic             viol_ready,
  output logic [W-1:0]     viol_prev,
  output logic [W-1:0]     viol_cur,
  output logic [CNT_W-1:0] viol_time,
  output logic [CNT_W-1:0] viol_cnt,
  output logic             overflow,
  output logic             busy
);
  chk_state_e state, nxt;
  logic [CNT_W-1:0] tick;
  logic [W-1:0] sig_q;
  logic strb_q_unused;
  pair_flags_t sig_f, strb_f;
  logic viol;
  gclk_sample_pair #(.W(W)) u_sig (.clk(clk), .rst(rst), .ld(busy), .d(sig), .q(sig_q), .f(sig_f));
  gclk_sample_pair #(.W(1)) u_strb (.clk(clk), .rst(rst), .ld(busy), .d(strb), .q(strb_q_unused), .f(strb_f));
  assign busy = state != IDLE;
  // RUN with en low is the exit cycle and is not evaluated.
  assign viol = state == RUN && en && chk_cons(CHK_CHANGE, sig_f) && !chk_cons(MODE, strb_f);
  always_comb
    nxt = !en ? IDLE : state == IDLE ? ARM : RUN;
  always_ff @(posedge clk)
    if (rst) begin
      state      <= IDLE;
      tick       <= '0;
      viol_valid <= 1'b0;
      viol_prev  <= '0;
      viol_cur   <= '0;
      viol_time  <= '0;
      viol_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      state <= nxt;
      if (busy) tick <= tick + 1'b1;
      if (viol && ~&viol_cnt) viol_cnt <= viol_cnt + 1'b1;
      if (viol && (!viol_valid || viol_ready)) begin
        viol_valid <= 1'b1;
        viol_prev  <= sig_q;
        viol_cur   <= sig;
        viol_time  <= tick;
      end else if (viol_ready) viol_valid <= 1'b0;
      if (viol && viol_valid && !viol_ready) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_gclk_edge_check_ctrl.sv
// tb_gclk_edge_check_ctrl: directed plus randomized checks of two checker instances against a streak-based model
module tb_gclk_edge_check_ctrl;
  import gclk_chk_pkg::*;
  logic clk = 0, rst = 1, en = 0, strb = 0, ready = 0;
  logic [3:0] sig = 0;
  logic a_valid, a_ovf, a_busy, b_valid, b_ovf, b_busy;
  logic [3:0] a_prev, a_cur, b_prev, b_cur;
  logic [15:0] a_time, a_cnt;
  logic [1:0] b_time, b_cnt;
  int checks = 0, failures = 0;
  int streak = 0;
  logic [3:0] p_sig = 0;
  logic p_strb = 0;
  bit mv[2], mo[2];
  logic [3:0] mp[2], mc[2];
  int mt[2], mn[2], tk[2];

  always #5 clk = ~clk;

  gclk_edge_check_ctrl #(.W(4), .CNT_W(16), .MODE(CHK_FALL)) dut_a (
    .clk(clk), .rst(rst), .en(en), .sig(sig), .strb(strb),
    .viol_valid(a_valid), .viol_ready(ready), .viol_prev(a_prev), .viol_cur(a_cur),
    .viol_time(a_time), .viol_cnt(a_cnt), .overflow(a_ovf), .busy(a_busy));

  gclk_edge_check_ctrl #(.W(4), .CNT_W(2), .MODE(CHK_CHANGE)) dut_b (
    .clk(clk), .rst(rst), .en(en), .sig(sig), .strb(strb),
    .viol_valid(b_valid), .viol_ready(ready), .viol_prev(b_prev), .viol_cur(b_cur),
    .viol_time(b_time), .viol_cnt(b_cnt), .overflow(b_ovf), .busy(b_busy));

  function automatic int cmax(int i);
    return i == 0 ? 65535 : 3;
  endfunction

  // A cycle is evaluated when en was high (outside reset) for the two previous
  // cycles and is high now; the counter ticks in every cycle preceded by an enabled one.
  always @(posedge clk) begin
    if (rst) begin
      streak = 0;
      for (int i = 0; i < 2; i++) begin
        mv[i] = 0; mo[i] = 0; mp[i] = 0; mc[i] = 0; mt[i] = 0; mn[i] = 0; tk[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit cons, v;
        cons = i == 0 ? (p_strb && !strb) : (strb != p_strb);
        v = streak >= 2 && en && sig != p_sig && !cons;
        if (v) begin
          if (mn[i] < cmax(i)) mn[i]++;
          if (!mv[i] || ready) begin
            mv[i] = 1; mp[i] = p_sig; mc[i] = sig; mt[i] = tk[i];
          end else mo[i] = 1;
        end else if (mv[i] && ready) mv[i] = 0;
        if (streak >= 1) tk[i] = (tk[i] + 1) % (cmax(i) + 1);
      end
      streak = en ? (streak >= 2 ? 2 : streak + 1) : 0;
    end
    p_sig = sig;
    p_strb = strb;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("a_valid", 32'(a_valid), 32'(mv[0]));
    chk("a_prev", 32'(a_prev), 32'(mp[0]));
    chk("a_cur", 32'(a_cur), 32'(mc[0]));
    chk("a_time", 32'(a_time), mt[0]);
    chk("a_cnt", 32'(a_cnt), mn[0]);
    chk("a_ovf", 32'(a_ovf), 32'(mo[0]));
    chk("a_busy", 32'(a_busy), 32'(streak >= 1));
    chk("b_valid", 32'(b_valid), 32'(mv[1]));
    chk("b_prev", 32'(b_prev), 32'(mp[1]));
    chk("b_cur", 32'(b_cur), 32'(mc[1]));
    chk("b_time", 32'(b_time), mt[1]);
    chk("b_cnt", 32'(b_cnt), mn[1]);
    chk("b_ovf", 32'(b_ovf), 32'(mo[1]));
    chk("b_busy", 32'(b_busy), 32'(streak >= 1));
  end

  task automatic cyc(input logic r, input logic e, input logic [3:0] s, input logic st, input logic rd);
    rst = r; en = e; sig = s; strb = st; ready = rd;
    @(negedge clk);
  endtask

  initial begin
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_cnt", 32'(a_cnt), 0);
    chk("rst_busy", 32'(a_busy), 0);
    cyc(0, 1, 0, 1, 0);
    chk("arm_busy", 32'(a_busy), 1);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 5, 0, 0);
    chk("fall_ok_valid", 32'(a_valid), 0);
    chk("fall_ok_cnt", 32'(a_cnt), 0);
    cyc(0, 1, 6, 0, 0);
    chk("viol_valid", 32'(a_valid), 1);
    chk("viol_prev", 32'(a_prev), 5);
    chk("viol_cur", 32'(a_cur), 6);
    chk("viol_time", 32'(a_time), 2);
    chk("viol_cnt", 32'(a_cnt), 1);
    cyc(0, 1, 6, 0, 1);
    chk("accept_valid", 32'(a_valid), 0);
    cyc(0, 0, 6, 0, 0);
    chk("exit_busy", 32'(a_busy), 0);
    cyc(0, 0, 9, 1, 0);
    cyc(0, 1, 3, 1, 0);
    cyc(0, 1, 4, 1, 0);
    chk("arm_sup_valid", 32'(a_valid), 0);
    chk("arm_sup_cnt", 32'(a_cnt), 1);
    cyc(0, 1, 8, 1, 0);
    chk("first_eval_valid", 32'(a_valid), 1);
    chk("first_eval_prev", 32'(a_prev), 4);
    chk("first_eval_cur", 32'(a_cur), 8);
    cyc(0, 1, 9, 1, 1);
    chk("simul_valid", 32'(a_valid), 1);
    chk("simul_prev", 32'(a_prev), 8);
    chk("simul_cur", 32'(a_cur), 9);
    chk("simul_ovf", 32'(a_ovf), 0);
    chk("simul_cnt", 32'(a_cnt), 3);
    cyc(0, 1, 9, 1, 1);
    for (int i = 1; i <= 3; i++) cyc(0, 1, 4'(i), 1, 0);
    chk("bp_prev", 32'(a_prev), 9);
    chk("bp_cur", 32'(a_cur), 1);
    chk("bp_cnt", 32'(a_cnt), 6);
    chk("bp_ovf", 32'(a_ovf), 1);
    cyc(0, 1, 3, 1, 1);
    chk("bp_drain_valid", 32'(a_valid), 0);
    chk("bp_drain_ovf", 32'(a_ovf), 1);
    cyc(0, 1, 4, 1, 0);
    chk("pre_rst_cnt", 32'(a_cnt), 7);
    cyc(1, 1, 4, 1, 0);
    chk("mid_rst_all", {a_valid, a_ovf, a_busy, a_prev, a_cur, a_time, a_cnt[8:0]}, 0);
    chk("mid_rst_cnt", 32'(a_cnt), 0);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    for (int i = 1; i <= 5; i++) cyc(0, 1, 4'(i), 0, 1);
    chk("sat_b_cnt", 32'(b_cnt), 3);
    chk("sat_a_cnt", 32'(a_cnt), 5);
    for (int n = 0; n < 3000; n++)
      cyc(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) != 0), 4'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
